// File: rtl/seg_pkg.sv
// Shared constants, FSM state type and counter-width helper for the segment scan multiplexer.
package seg_pkg;

   localparam int SEG_W = 7;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'h00;

   typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_e;

   // Width needed to hold 0..div-1, never narrower than one bit.
   function automatic int cnt_width(input int div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Slot-time prescaler: counts 0..SCAN_DIV-1 while enabled, synchronous clear wins over enable.
module scan_prescaler
   import seg_pkg::*;
#(
   parameter int SCAN_DIV = 50000,
   parameter int CNT_W    = cnt_width(SCAN_DIV)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CNT_W-1:0] cnt_nxt_o,
   output logic             wrap_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      wrap_o = en_i && !clr_i && (cnt_q == CNT_MAX);
      cnt_d  = cnt_q;
      if (clr_i || wrap_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The mux decodes its outputs from the value being loaded, so expose the next count.
   assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexes N_DIGITS 7-segment patterns onto one segment bus with per-slot blanking.
// Define SEG_ACTIVE_LOW_EN for common-anode boards (o_seg/o_dig inverted at the output flops).
module seg_scan_mux
   import seg_pkg::*;
#(
   parameter int N_DIGITS  = 2,
   parameter int SCAN_DIV  = 50000,
   parameter int BLANK_CYC = 500
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_en,
   input  logic [SEG_W*N_DIGITS-1:0] i_seg_bus,
   output logic [SEG_W-1:0]          o_seg,
   output logic [N_DIGITS-1:0]       o_dig,
   output logic                      o_frame
);

   localparam int CNT_W  = cnt_width(SCAN_DIV);
   localparam int SLOT_W = cnt_width(N_DIGITS);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(N_DIGITS - 1);
   localparam logic [CNT_W-1:0]  BLANK_END = CNT_W'(BLANK_CYC);

`ifdef SEG_ACTIVE_LOW_EN
   localparam logic [SEG_W-1:0]    SEG_POL = '1;
   localparam logic [N_DIGITS-1:0] DIG_POL = '1;
`else
   localparam logic [SEG_W-1:0]    SEG_POL = '0;
   localparam logic [N_DIGITS-1:0] DIG_POL = '0;
`endif

   scan_state_e                state_q, state_d;
   logic [SLOT_W-1:0]          slot_q, slot_d;
   logic [SEG_W*N_DIGITS-1:0]  snap_q, snap_d;
   logic [SEG_W-1:0]           seg_q, seg_d;
   logic [N_DIGITS-1:0]        dig_q, dig_d;
   logic                       frame_q, frame_d;

   logic             run;
   logic [CNT_W-1:0] cnt_nxt;
   logic             wrap;
   logic             in_blank;

   assign run = i_en && (state_q != IDLE);

   scan_prescaler #(
      .SCAN_DIV (SCAN_DIV),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk_i     (i_clk),
      .rst_ni    (i_rst_n),
      .en_i      (run),
      .clr_i     (!run),
      .cnt_nxt_o (cnt_nxt),
      .wrap_o    (wrap)
   );

   generate
      if (BLANK_CYC == 0) begin : g_no_blank
         assign in_blank = 1'b0;
      end else begin : g_blank
         assign in_blank = (cnt_nxt < BLANK_END);
      end
   endgenerate

   // Frame start (first enabled edge, or last slot wrapping) is the only point the snapshot loads.
   always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      snap_d  = snap_q;
      frame_d = 1'b0;
      if (!i_en) begin
         state_d = IDLE;
         slot_d  = '0;
      end else begin
         if (state_q == IDLE) begin
            slot_d  = '0;
            frame_d = 1'b1;
         end else if (wrap) begin
            if (slot_q == SLOT_LAST) begin
               slot_d  = '0;
               frame_d = 1'b1;
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         if (frame_d) begin
            snap_d = i_seg_bus;
         end
         state_d = in_blank ? BLANK : SHOW;
      end
   end

   always_comb begin
      seg_d = SEG_OFF;
      dig_d = '0;
      if (state_d == SHOW) begin
         for (int k = 0; k < N_DIGITS; k++) begin
            if (slot_d == SLOT_W'(k)) begin
               seg_d    = snap_d[SEG_W*k +: SEG_W];
               dig_d[k] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         snap_q  <= '0;
         seg_q   <= SEG_OFF ^ SEG_POL;
         dig_q   <= DIG_POL;
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         snap_q  <= snap_d;
         seg_q   <= seg_d ^ SEG_POL;
         dig_q   <= dig_d ^ DIG_POL;
         frame_q <= frame_d;
      end
   end

   assign o_seg   = seg_q;
   assign o_dig   = dig_q;
   assign o_frame = frame_q;

endmodule
